fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded at reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  read address; always equals pc.
REQ-006 imem_ready  input  1  read data valid this cycle; qualified by imem_req.
REQ-007 imem_rdata  input  32  instruction word; sampled when imem_req and imem_ready.
REQ-008 inst  output  32  held instruction, feeds top_controller inst.
REQ-009 inst_valid  output  1  inst is valid for decode/execute.
REQ-010 inst_ack  input  1  execute done with inst; redirect inputs valid this cycle.
REQ-011 pc / pc_plus4  output  32 each  address of inst, and pc+4 mod 2^32 (for jal/jalr rd).
REQ-012 branch_taken, jal, jalr  input  1 each  redirect requests, sampled only on accepted ack.
REQ-013 target  input  32  branch/jal target; jalr_target  input  32  raw rs1+imm sum.
REQ-014 misaligned  output  1  sticky fetch-address-misaligned flag.

Function
REQ-015 FSM states SHALL be FETCH, VALID, HALT; reset state is FETCH.
REQ-016 FETCH: imem_req=1, inst_valid=0; on imem_ready, inst<=imem_rdata, go VALID; else stay, imem_addr stable.
REQ-017 VALID: imem_req=0, inst_valid=1, inst and pc stable until inst_ack.
REQ-018 Accepted ack (VALID and inst_ack): pc<=next_pc, inst_valid drops next cycle, state FETCH.
REQ-019 next_pc priority: jalr -> {jalr_target[31:1],1'b0}; else jal or branch_taken -> target; else pc+4.
REQ-020 All adds 32-bit, wrap modulo 2^32 (pc 32'hFFFF_FFFC sequential -> 32'h0000_0000).
REQ-021 Accepted ack with next_pc[1:0]!=0: pc unchanged, misaligned<=1, state HALT.
REQ-022 HALT: imem_req=0, inst_valid=0, all inputs ignored; exit only by reset.
REQ-023 imem_ready without imem_req, and inst_ack outside VALID, SHALL be ignored.
REQ-024 Minimum throughput: one instruction per 2 cycles (ready in FETCH cycle, ack in VALID cycle).
REQ-025 First imem_req SHALL be high in the first cycle after rst_n deasserts; imem_addr=RESET_PC.

Reset
REQ-026 rst_n low asynchronously forces: state FETCH, pc=RESET_PC, inst=32'h0000_0013 (nop), misaligned=0.
REQ-027 During reset: imem_req=0, inst_valid=0; pc_plus4=RESET_PC+4.
REQ-028 Reset mid-request or mid-VALID SHALL discard the in-flight/held instruction; no ack completion.

Structure
REQ-029 Shared package: state enum, RESET_PC default, NOP encoding 32'h0000_0013.
REQ-030 One combinational sub-module next_pc_sel: priority select plus misalignment check.
REQ-031 Only pc, inst, state, misaligned are registers; no other storage.

Verification
REQ-032 Reset release, imem_ready=1 with rdata 32'h00500093 -> req at addr 0, next cycle inst_valid=1, inst=32'h00500093.
REQ-033 imem_ready held low 3 cycles -> imem_req stays 1, addr stable, inst_valid 0; capture on 4th cycle.
REQ-034 Ack with jal=1,branch_taken=1,jalr=1,jalr_target=32'h0000_0105 -> next imem_addr 32'h0000_0104.
REQ-035 Ack with branch_taken=1,target=32'h0000_0102 -> misaligned=1, HALT, imem_req stays 0 for 10 cycles.
REQ-036 pc=32'hFFFF_FFFC, ack with no redirect -> next imem_addr 32'h0000_0000; pc_plus4 was 0.
REQ-037 rst_n low while in VALID -> immediately inst_valid=0, pc=RESET_PC; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// fetch_unit_pkg : shared state encoding and constants for the fetch unit
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        VALID = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;

endpackage : fetch_unit_pkg

`default_nettype wire

// File: rtl/fetch_unit_next_pc_sel.sv
// ============================================================================
// next_pc_sel : redirect priority select and fetch-address alignment check
// Rev 1.0
// ============================================================================
`default_nettype none

module next_pc_sel (
    input  logic [31:0] pc_plus4,
    input  logic        branch_taken,
    input  logic        jal,
    input  logic        jalr,
    input  logic [31:0] target,
    input  logic [31:0] jalr_target,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] jalr_masked;

    // jalr discards bit 0 of the rs1+imm sum; bit 1 can still misalign
    assign jalr_masked = jalr_target & ~32'd1;

    always_comb begin
        next_pc = pc_plus4;
        if (jalr) begin
            next_pc = jalr_masked;
        end else if (jal || branch_taken) begin
            next_pc = target;
        end
    end

    assign misaligned = |next_pc[1:0];

endmodule : next_pc_sel

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : single-outstanding instruction fetch with redirect and halt
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_ack,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        branch_taken,
    input  logic        jal,
    input  logic        jalr,
    input  logic [31:0] target,
    input  logic [31:0] jalr_target,
    output logic        misaligned
);

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic [31:0]  pc_nxt;
    logic [31:0]  inst_nxt;
    logic         misaligned_nxt;
    logic [31:0]  sel_next_pc;
    logic         sel_misaligned;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    next_pc_sel u_next_pc_sel (
        .pc_plus4     (pc_plus4),
        .branch_taken (branch_taken),
        .jal          (jal),
        .jalr         (jalr),
        .target       (target),
        .jalr_target  (jalr_target),
        .next_pc      (sel_next_pc),
        .misaligned   (sel_misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            inst       <= NOP_INSN;
            misaligned <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            inst       <= inst_nxt;
            misaligned <= misaligned_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        inst_nxt       = inst;
        misaligned_nxt = misaligned;
        imem_req       = 1'b0;
        inst_valid     = 1'b0;
        case (state)
            FETCH: begin
                // state already sits in FETCH while reset is held; keep the request quiet
                imem_req = rst_n;
                if (imem_ready) begin
                    inst_nxt  = imem_rdata;
                    state_nxt = VALID;
                end
            end
            VALID: begin
                inst_valid = 1'b1;
                if (inst_ack) begin
                    if (sel_misaligned) begin
                        misaligned_nxt = 1'b1;
                        state_nxt      = HALT;
                    end else begin
                        pc_nxt    = sel_next_pc;
                        state_nxt = FETCH;
                    end
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

endmodule : fetch_unit

`default_nettype wire
